// File: rtl/cl_pixel_packer_pkg.sv
// Shared definitions for the Camera Link pixel packer.
// Holds the framing FSM encoding, the 4-pixel group field slices and the log2 helper.
package cl_pixel_packer_pkg;

  localparam int unsigned PX_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Group field slices: p0 (leftmost) in the MSBs, p3 in the LSBs.
  localparam int unsigned P0_MSB = 4 * PX_W_DEF - 1;
  localparam int unsigned P0_LSB = 3 * PX_W_DEF;
  localparam int unsigned P1_MSB = 3 * PX_W_DEF - 1;
  localparam int unsigned P1_LSB = 2 * PX_W_DEF;
  localparam int unsigned P2_MSB = 2 * PX_W_DEF - 1;
  localparam int unsigned P2_LSB = PX_W_DEF;
  localparam int unsigned P3_MSB = PX_W_DEF - 1;
  localparam int unsigned P3_LSB = 0;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/cl_pixel_packer_pixel_group_packer.sv
// pixel_group_packer: 3-to-4 residual buffer for one sensor row.
// Ports: cl_clk/reset; beat appends 3 pixels, flush closes the line, clear drops
// the residual; group_c/emit_c/partial_c/short_c are the combinational results.
module pixel_group_packer
  import cl_pixel_packer_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE = PX_W_DEF
) (
  input  logic                    cl_clk,
  input  logic                    reset,
  input  logic                    beat,
  input  logic                    flush,
  input  logic                    clear,
  input  logic [3*PIXEL_SIZE-1:0] pixels,
  output logic [4*PIXEL_SIZE-1:0] group_c,
  output logic                    emit_c,
  output logic                    partial_c,
  output logic                    short_c
);

  logic [1:0]            cnt, cnt_d;
  logic [PIXEL_SIZE-1:0] r0, r1, r2, r0_d, r1_d, r2_d;
  logic [PIXEL_SIZE-1:0] n0, n1, n2;

  assign n0 = pixels[3*PIXEL_SIZE-1 -: PIXEL_SIZE];
  assign n1 = pixels[2*PIXEL_SIZE-1 -: PIXEL_SIZE];
  assign n2 = pixels[PIXEL_SIZE-1 -: PIXEL_SIZE];

  // Residual buffer state; r0 is always the oldest pixel.
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
      r0  <= '0;
      r1  <= '0;
      r2  <= '0;
    end else begin
      cnt <= cnt_d;
      r0  <= r0_d;
      r1  <= r1_d;
      r2  <= r2_d;
    end
  end

  // Oldest four of (residual ++ new beat) form the group; leftovers shift down.
  always_comb begin
    cnt_d     = cnt;
    r0_d      = r0;
    r1_d      = r1;
    r2_d      = r2;
    group_c   = '0;
    emit_c    = 1'b0;
    partial_c = 1'b0;
    short_c   = 1'b0;
    if (beat) begin
      case (cnt)
        2'd0: begin
          r0_d  = n0;
          r1_d  = n1;
          r2_d  = n2;
          cnt_d = 2'd3;
        end
        2'd1: begin
          group_c = {r0, n0, n1, n2};
          emit_c  = 1'b1;
          cnt_d   = 2'd0;
        end
        2'd2: begin
          group_c = {r0, r1, n0, n1};
          emit_c  = 1'b1;
          r0_d    = n2;
          cnt_d   = 2'd1;
        end
        default: begin
          group_c = {r0, r1, r2, n0};
          emit_c  = 1'b1;
          r0_d    = n1;
          r1_d    = n2;
          cnt_d   = 2'd2;
        end
      endcase
    end else if (flush) begin
      if (cnt == 2'd3) begin
        group_c   = {r0, r1, r2, PIXEL_SIZE'(0)};
        emit_c    = 1'b1;
        partial_c = 1'b1;
      end
      short_c = (cnt == 2'd1) || (cnt == 2'd2);
      cnt_d   = 2'd0;
    end else if (clear) begin
      cnt_d = 2'd0;
    end
  end

endmodule

// File: rtl/cl_pixel_packer.sv
// cl_pixel_packer: Camera Link front end. Repacks 3-pixel beats (top and bottom
// rows) into 4-pixel column groups, tracks frame/line framing and the row index.
// Ports: cl_clk, reset (async, active-high); fval/lval/dval framing; tap_top/tap_btm
// 3-pixel beats; err_clr. Outputs: pixel012_valid/pixel3_valid, l_col/r_col,
// pixel_top/pixel_btm groups, row, frame_start/line_end pulses, err_short/err_ovf.
module cl_pixel_packer
  import cl_pixel_packer_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE = PX_W_DEF,
  parameter int unsigned N_COL_SIZE = 12,
  parameter int unsigned N_ROW_SIZE = 11,
  parameter int unsigned LINE_WIDTH = 1536
) (
  input  logic                    cl_clk,
  input  logic                    reset,
  input  logic                    fval,
  input  logic                    lval,
  input  logic                    dval,
  input  logic [3*PIXEL_SIZE-1:0] tap_top,
  input  logic [3*PIXEL_SIZE-1:0] tap_btm,
  input  logic                    err_clr,
  output logic                    pixel012_valid,
  output logic                    pixel3_valid,
  output logic [N_COL_SIZE-1:0]   l_col,
  output logic [N_COL_SIZE-1:0]   r_col,
  output logic [4*PIXEL_SIZE-1:0] pixel_top,
  output logic [4*PIXEL_SIZE-1:0] pixel_btm,
  output logic [N_ROW_SIZE-1:0]   row,
  output logic                    frame_start,
  output logic                    line_end,
  output logic                    err_short,
  output logic                    err_ovf
);

  localparam int unsigned CNT_W = clog2(LINE_WIDTH + 4);

  state_t                  state, state_d;
  logic                    fval_prev, lval_prev;
  logic                    fval_rise, lval_rise;
  logic                    beat, fits, accept, ovf_event, flush, clear, flush_cycle;
  logic [CNT_W-1:0]        pix_cnt;
  logic [N_COL_SIZE-1:0]   col_cnt;
  logic                    ovf_line;
  logic [4*PIXEL_SIZE-1:0] grp_top, grp_btm;
  logic                    emit_top, emit_btm, partial_top, partial_btm, short_top, short_btm;
  logic                    emit, partial, short_ev;

  assign fval_rise = fval & ~fval_prev;
  assign lval_rise = lval & ~lval_prev;

  // The lval rising cycle is already the first beat of the line.
  assign beat = fval & lval & dval &
                ((state == ST_LINE) | ((state == ST_FRAME) & lval_rise));
  assign fits        = (pix_cnt + CNT_W'(3)) <= CNT_W'(LINE_WIDTH);
  assign accept      = beat & fits & ~ovf_line;
  assign ovf_event   = beat & ~fits;
  assign flush_cycle = fval & (state == ST_FLUSH);
  assign flush       = flush_cycle & ~ovf_line;
  assign clear       = (state != ST_LINE);

  // Both rows share control, so their flags match; OR-ing keeps both observed.
  assign emit     = emit_top | emit_btm;
  assign partial  = partial_top | partial_btm;
  assign short_ev = short_top | short_btm;

  pixel_group_packer #(.PIXEL_SIZE(PIXEL_SIZE)) u_pack_top (
    .cl_clk    (cl_clk),
    .reset     (reset),
    .beat      (accept),
    .flush     (flush),
    .clear     (clear),
    .pixels    (tap_top),
    .group_c   (grp_top),
    .emit_c    (emit_top),
    .partial_c (partial_top),
    .short_c   (short_top)
  );

  pixel_group_packer #(.PIXEL_SIZE(PIXEL_SIZE)) u_pack_btm (
    .cl_clk    (cl_clk),
    .reset     (reset),
    .beat      (accept),
    .flush     (flush),
    .clear     (clear),
    .pixels    (tap_btm),
    .group_c   (grp_btm),
    .emit_c    (emit_btm),
    .partial_c (partial_btm),
    .short_c   (short_btm)
  );

  // FSM state register.
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Framing next-state; fval low overrides everything.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (fval_rise) state_d = ST_FRAME;
      ST_FRAME: if (lval_rise) state_d = ST_LINE;
      ST_LINE:  if (!lval)     state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_FRAME;
      default:  state_d = ST_IDLE;
    endcase
    if (!fval) state_d = ST_IDLE;
  end

  // Edge detectors reset high so a frame already in progress at reset release is skipped.
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      fval_prev <= 1'b1;
      lval_prev <= 1'b1;
    end else begin
      fval_prev <= fval;
      lval_prev <= lval;
    end
  end

  // Per-line counters; held at zero outside a line.
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      pix_cnt  <= '0;
      col_cnt  <= '0;
      ovf_line <= 1'b0;
    end else begin
      if (accept)                pix_cnt <= pix_cnt + CNT_W'(3);
      else if (state != ST_LINE) pix_cnt <= '0;

      if (emit & ~partial)       col_cnt <= col_cnt + N_COL_SIZE'(4);
      else if (state != ST_LINE) col_cnt <= '0;

      if (ovf_event)             ovf_line <= 1'b1;
      else if (state != ST_LINE) ovf_line <= 1'b0;
    end
  end

  // Registered output bus.
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      pixel012_valid <= 1'b0;
      pixel3_valid   <= 1'b0;
      l_col          <= '0;
      r_col          <= '0;
      pixel_top      <= '0;
      pixel_btm      <= '0;
      row            <= '0;
      frame_start    <= 1'b0;
      line_end       <= 1'b0;
      err_short      <= 1'b0;
      err_ovf        <= 1'b0;
    end else begin
      pixel012_valid <= emit;
      pixel3_valid   <= emit & ~partial;
      if (emit) begin
        l_col     <= col_cnt;
        r_col     <= col_cnt + (partial ? N_COL_SIZE'(2) : N_COL_SIZE'(3));
        pixel_top <= grp_top;
        pixel_btm <= grp_btm;
      end
      frame_start <= (state == ST_IDLE) & fval_rise;
      line_end    <= flush_cycle;
      if ((state == ST_IDLE) & fval_rise) row <= '0;
      else if (flush_cycle)               row <= row + N_ROW_SIZE'(1);
      // A new error event beats a simultaneous clear.
      err_short <= short_ev  | (err_short & ~err_clr);
      err_ovf   <= ovf_event | (err_ovf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_cl_pixel_packer.sv
// Scoreboard bench for cl_pixel_packer: randomized beats feed a line-level model
// (pixel list per line, groups = consecutive quadruples) that queues expected groups.
module tb_cl_pixel_packer;
  import cl_pixel_packer_pkg::*;

  localparam int unsigned LW = 1536;

  logic        cl_clk = 1'b0;
  logic        reset  = 1'b0;
  logic        fval = 1'b0, lval = 1'b0, dval = 1'b0, err_clr = 1'b0;
  logic [35:0] tap_top = '0, tap_btm = '0;
  logic        pixel012_valid, pixel3_valid, frame_start, line_end, err_short, err_ovf;
  logic [11:0] l_col, r_col;
  logic [47:0] pixel_top, pixel_btm;
  logic [10:0] row;

  cl_pixel_packer #(
    .PIXEL_SIZE(12), .N_COL_SIZE(12), .N_ROW_SIZE(11), .LINE_WIDTH(LW)
  ) dut (
    .cl_clk(cl_clk), .reset(reset), .fval(fval), .lval(lval), .dval(dval),
    .tap_top(tap_top), .tap_btm(tap_btm), .err_clr(err_clr),
    .pixel012_valid(pixel012_valid), .pixel3_valid(pixel3_valid),
    .l_col(l_col), .r_col(r_col), .pixel_top(pixel_top), .pixel_btm(pixel_btm),
    .row(row), .frame_start(frame_start), .line_end(line_end),
    .err_short(err_short), .err_ovf(err_ovf)
  );

  always #5 cl_clk = ~cl_clk;

  int cyc = 0;
  always @(posedge cl_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [11:0] lcol;
    logic [11:0] rcol;
    logic [47:0] top;
    logic [47:0] btm;
    logic        p3;
    int          row;
    bit          chk_row;
  } grp_t;

  grp_t        grp_q[$];
  int          le_cyc_q[$];
  int          le_row_q[$];
  int          fs_q[$];
  logic [11:0] mt[$];
  logic [11:0] mb[$];
  int          acc = 0;
  bit          line_ovf = 0;
  int          exp_row = 0;
  bit          exp_short = 0, exp_ovf = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output pulse at cycle %0d, none required", name, cyc);
  endtask

  function automatic logic [35:0] rnd36();
    return 36'({$urandom(), $urandom()});
  endfunction

  task automatic step(input logic fv, input logic lv, input logic dv,
                      input logic [35:0] tt, input logic [35:0] tb);
    @(posedge cl_clk);
    #1;
    fval = fv; lval = lv; dval = dv; tap_top = tt; tap_btm = tb;
  endtask

  task automatic push_group(input int g, input int at, input bit partial);
    grp_t e;
    e.cyc  = at;
    e.lcol = 12'(4 * g);
    e.rcol = 12'(4 * g + (partial ? 2 : 3));
    e.top  = '0;
    e.btm  = '0;
    e.top[P0_MSB:P0_LSB] = mt[4*g];   e.btm[P0_MSB:P0_LSB] = mb[4*g];
    e.top[P1_MSB:P1_LSB] = mt[4*g+1]; e.btm[P1_MSB:P1_LSB] = mb[4*g+1];
    e.top[P2_MSB:P2_LSB] = mt[4*g+2]; e.btm[P2_MSB:P2_LSB] = mb[4*g+2];
    if (!partial) begin
      e.top[P3_MSB:P3_LSB] = mt[4*g+3];
      e.btm[P3_MSB:P3_LSB] = mb[4*g+3];
    end
    e.p3      = !partial;
    e.row     = exp_row;
    e.chk_row = !partial;
    grp_q.push_back(e);
  endtask

  // One beat; in ramp mode top pixels carry their column index.
  task automatic beat(input bit ramp);
    logic [11:0] pt [3];
    logic [11:0] pb [3];
    for (int i = 0; i < 3; i++) begin
      pt[i] = ramp ? 12'(acc + i) : 12'($urandom());
      pb[i] = 12'($urandom());
    end
    step(1'b1, 1'b1, 1'b1, {pt[0], pt[1], pt[2]}, {pb[0], pb[1], pb[2]});
    if (acc + 3 <= int'(LW)) begin
      for (int i = 0; i < 3; i++) begin
        mt.push_back(pt[i]);
        mb.push_back(pb[i]);
      end
      acc += 3;
      if ((acc / 4) != ((acc - 3) / 4)) push_group(acc / 4 - 1, cyc + 1, 1'b0);
    end else begin
      line_ovf = 1;
      exp_ovf  = 1;
    end
  endtask

  task automatic gap();
    step(1'b1, 1'b1, 1'b0, rnd36(), rnd36());
  endtask

  task automatic end_line();
    int k;
    step(1'b1, 1'b0, 1'b0, rnd36(), rnd36());
    k = cyc;
    if (!line_ovf && (acc % 4 == 3)) push_group(acc / 4, k + 2, 1'b1);
    if (!line_ovf && (acc % 4 == 1 || acc % 4 == 2)) exp_short = 1;
    exp_row = (exp_row + 1) % 2048;
    le_cyc_q.push_back(k + 2);
    le_row_q.push_back(exp_row);
    acc = 0;
    line_ovf = 0;
    mt.delete();
    mb.delete();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic run_line(input int nb, input bit ramp, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps && i > 0) begin
        int ng;
        ng = int'($urandom_range(0, 2));
        repeat (ng) gap();
      end
      beat(ramp);
    end
    end_line();
  endtask

  task automatic start_frame();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    fs_q.push_back(cyc + 1);
    exp_row = 0;
    step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_short"}, 64'(err_short), 64'(exp_short));
    check({tag, "_err_ovf"}, 64'(err_ovf), 64'(exp_ovf));
  endtask

  task automatic clear_errs(input string tag);
    @(posedge cl_clk);
    #1 err_clr = 1'b1;
    @(posedge cl_clk);
    #1 err_clr = 1'b0;
    exp_short = 0;
    exp_ovf   = 0;
    check_errs(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({pixel012_valid, pixel3_valid, frame_start, line_end,
                              err_short, err_ovf, row, l_col, r_col}), 64'd0);
    check({tag, "_top"}, 64'(pixel_top), 64'd0);
    check({tag, "_btm"}, 64'(pixel_btm), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a group or pulse.
  always @(negedge cl_clk) begin
    grp_t e;
    int   c;
    if (pixel012_valid) begin
      if (grp_q.size() == 0) unexpected("group");
      else begin
        e = grp_q.pop_front();
        check("grp_cycle", 64'(cyc), 64'(e.cyc));
        check("grp_l_col", 64'(l_col), 64'(e.lcol));
        check("grp_r_col", 64'(r_col), 64'(e.rcol));
        check("grp_top", 64'(pixel_top), 64'(e.top));
        check("grp_btm", 64'(pixel_btm), 64'(e.btm));
        check("grp_p3_valid", 64'(pixel3_valid), 64'(e.p3));
        if (e.chk_row) check("grp_row", 64'(row), 64'(e.row));
      end
    end else if (pixel3_valid) begin
      unexpected("pixel3_without_012");
    end
    if (line_end) begin
      if (le_cyc_q.size() == 0) unexpected("line_end");
      else begin
        c = le_cyc_q.pop_front();
        check("line_end_cycle", 64'(cyc), 64'(c));
        c = le_row_q.pop_front();
        check("row_after_line", 64'(row), 64'(c));
      end
    end
    if (frame_start) begin
      if (fs_q.size() == 0) unexpected("frame_start");
      else begin
        c = fs_q.pop_front();
        check("frame_start_cycle", 64'(cyc), 64'(c));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    #1 check_zero("reset");
    repeat (3) @(posedge cl_clk);
    #1 reset = 1'b0;

    start_frame();
    run_line(512, 1'b1, 1'b0);           // 384 full groups, column ramp
    check("row_line0_done", 64'(row), 64'd1);
    check_errs("after_full_line");
    run_line(5, 1'b0, 1'b0);             // 3 full + partial on flush
    check_errs("after_partial_line");
    run_line(2, 1'b0, 1'b0);             // residual 2 dropped
    check_errs("after_short_line");
    clear_errs("short_cleared");

    // dval pattern 1,0,0,1,1,0,1
    beat(1'b0); gap(); gap(); beat(1'b0); beat(1'b0); gap(); beat(1'b0);
    end_line();
    run_line(40, 1'b0, 1'b1);
    run_line(513, 1'b0, 1'b0);           // one beat beyond the line width
    check_errs("after_overflow");
    clear_errs("ovf_cleared");
    run_line(21, 1'b0, 1'b1);
    check_errs("after_recovery_line");

    // Reset mid-line with framing still active.
    start_frame();
    for (int i = 0; i < 100; i++) beat(1'b0);
    gap();
    @(negedge cl_clk);
    #1 reset = 1'b1;
    #1 check_zero("midline_reset");
    check("pending_at_reset", 64'(grp_q.size()), 64'd0);
    grp_q.delete(); le_cyc_q.delete(); le_row_q.delete(); fs_q.delete();
    mt.delete(); mb.delete();
    acc = 0; line_ovf = 0; exp_short = 0; exp_ovf = 0;
    fval = 1'b1; lval = 1'b1; dval = 1'b1;
    repeat (2) @(posedge cl_clk);
    #1 reset = 1'b0;
    repeat (12) step(1'b1, 1'b1, 1'b1, rnd36(), rnd36());
    check("row_after_release", 64'(row), 64'd0);
    check_zero("quiet_after_release");

    start_frame();
    run_line(8, 1'b0, 1'b1);
    run_line(7, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, '0, '0);

    check("groups_drained", 64'(grp_q.size()), 64'd0);
    check("line_ends_drained", 64'(le_cyc_q.size()), 64'd0);
    check("frame_starts_drained", 64'(fs_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cl_pixel_packer.md
Name: cl_pixel_packer

Overview:
- Camera-Link-side front end in the cl_clk domain.
- Input: 3 pixels/clock per sensor half (6 taps, 12-bit: 3 from the top row, 3 from the bottom row).
- Repacks the beats into 4-pixel column groups with column tags and drives the pixel012_valid/pixel3_valid/l_col/r_col/pixel_top/pixel_btm bus that every patch row reducer samples.
- Also tracks the row number and frame/line framing.

Parameters:
- PIXEL_SIZE, 12, bits per pixel.
- N_COL_SIZE, 12, width of column numbers.
- N_ROW_SIZE, 11, width of row counter.
- LINE_WIDTH, 1536, pixels per line. Must be a multiple of 3, and LINE_WIDTH mod 4 must be 0 or 3.

Ports:
- cl_clk  in  1  Camera Link pixel clock.
- reset  in  1  asynchronous, active-high.
- fval  in  1  frame valid.
- lval  in  1  line valid.
- dval  in  1  data valid.
- tap_top  in  3*PIXEL_SIZE  top-row pixels; leftmost pixel in the MSBs.
- tap_btm  in  3*PIXEL_SIZE  bottom-row pixels; same ordering.
- err_clr  in  1  clears the sticky errors.
- pixel012_valid  out  1  group carries at least pixels 0..2.
- pixel3_valid  out  1  group carries pixel 3 as well (full group).
- l_col  out  N_COL_SIZE  column of pixel 0.
- r_col  out  N_COL_SIZE  column of the rightmost valid pixel.
- pixel_top  out  4*PIXEL_SIZE  top-row group; p0 in [47:36] … p3 in [11:0].
- pixel_btm  out  4*PIXEL_SIZE  bottom-row group; same ordering.
- row  out  N_ROW_SIZE  row index of the current group.
- frame_start  out  1  one-cycle pulse on fval rise.
- line_end  out  1  one-cycle pulse after the last group of a line.
- err_short  out  1  sticky: line ended with 1 or 2 residual pixels.
- err_ovf  out  1  sticky: line exceeded LINE_WIDTH.

Behaviour:
- Clocking/reset: single clock cl_clk; reset asynchronous, active-high. Reset clears all outputs to 0 (valids, pulses, cols, row, pixel buses, errors) and puts the FSM in IDLE.
- FSM states:
  - IDLE → FRAME on fval rising edge. Pulse frame_start; row ← 0.
  - FRAME → LINE on lval rising edge while fval=1. Column count ← 0, residual ← 0.
  - LINE: a beat is a cycle with lval&dval.
  - LINE → FLUSH on the first cycle with lval=0.
  - FLUSH → FRAME after one cycle; row ← row+1.
  - Any state → IDLE when fval=0.
- Mid-operation start: if reset releases with lval or fval already high, the block waits for a fresh fval rising edge. Partial frames are ignored.
- Packing:
  - Per-row residual buffer holds up to 3 pixels; count c ∈ {0..3}.
  - Each beat appends 3 pixels. If c+3 ≥ 4, emit the oldest 4 as a group and set c ← c−1; else c ← c+3.
  - At most one emit per beat.
- Output timing:
  - Group outputs are registered: valids assert the cycle after the completing beat. Latency is 1 cycle, and the valids are high for exactly one cycle per group.
  - Full group: pixel012_valid=1, pixel3_valid=1, r_col = l_col+3.
  - l_col starts at 0 each line and advances by 4 per full group.
- FLUSH cycle:
  - c=3: emit partial group, pixel012_valid=1, pixel3_valid=0, r_col = l_col+2, pixel bits [11:0] = 0.
  - c=0: no group.
  - c=1 or 2: residual dropped, err_short set.
  - line_end pulses in the same cycle as the flushed group, or alone when no group is emitted.
- Overflow: beats after LINE_WIDTH pixels are dropped, err_ovf set, and no groups are emitted for the rest of the line. Columns never wrap.
- dval=0 within lval: no beat, state held.
- err_clr and an error event in the same cycle: the error wins.
- row wraps modulo 2^N_ROW_SIZE. Top and bottom rows share one row counter; the bottom-row offset is the consumer's concern.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, FRAME, LINE, FLUSH);
  - group-field slicing constants (P0_MSB…P3_LSB);
  - the log2 helper already used across the design.
- One natural sub-module, pixel_group_packer: the 3-to-4 residual buffer for a single row. Instantiate it twice (top and bottom) with a common beat/flush control; it returns group data plus the emit and partial flags.

Test Plan:
- Reset, then fval rise, lval high for 512 beats, pixels = column index → 384 full groups; first group l_col=0, r_col=3, pixel_top=0x000_001_002_003; last group l_col=1532. One line_end pulse; row=0, then 1 after FLUSH.
- LINE_WIDTH=15 build, 5 beats → 3 full groups, then a partial group on FLUSH with l_col=12, r_col=14, pixel3_valid=0; err_short=0.
- LINE_WIDTH=6 build, line of 2 beats → 1 full group; residual 2 dropped; err_short=1 until err_clr.
- dval toggles 1,0,0,1,1,0,1 within a line → groups identical to a gap-free run, each 1 cycle after its completing beat.
- 513 beats on LINE_WIDTH=1536 → 384 groups; extra beat dropped; err_ovf=1.
- Reset asserted mid-line after 100 beats → outputs 0 immediately; with lval still high at release, nothing is emitted until the next fval rise.
